timer_enable_sequencer: RTL
===========================

// Module: timer_enable_sequencer
// PURPOSE
//  Drives the timer peripheral's enable input with a programmed train of N pulses: each pulse is
//  HIGH ticks high, then LOW ticks low. Configured by the host over an APB2 slave port.
//  Sits between the APB bus and the timer's logical_in[0], so pulse-sum and one-shot measurements
//  run with exact, repeatable enable patterns.
// PARAMETERS
//  IO_LOGICAL  8   width of the logical_in/val/drive buses
// PORTS
//  clk            in   1          system clock; the only clock
//  rst_n          in   1          synchronous active-low reset
//  trig           in   1          external arm trigger (rising edge), already synchronous to clk
//  timer_enable   out  1          enable output to the timer
//  busy           out  1          sequence in progress (ARMED/HIGH/LOW)
//  PADDR          in   12         APB address
//  PSEL           in   1          APB select
//  PENABLE        in   1          APB enable
//  PWRITE         in   1          APB write
//  PWDATA         in   8          APB write data
//  PRDATA         out  8          APB read data (registered)
// BEHAVIOUR
//  Register map, byte-wide, little-endian:
//    +0..3   high_ticks (RW, 32b)        +4..7 low_ticks (RW, 32b)   +8..9 pulse_count (RW, 16b)
//    +10     ctrl (WO): [0] start (self-clearing), [1] abort, [2] arm_on_trig
//    +11     status (RO): [0] busy, [1] done (sticky)   +12..13 pulses_done (RO, 16b)
//    Other addresses: reads return 0; writes are ignored.
//  Write strobe = PSEL&PWRITE&PENABLE. Read: PRDATA updates on the clk edge where PSEL&!PWRITE.
//  Reset: all registers 0; state IDLE; timer_enable=0; busy=0; PRDATA=0; done=0.
//  FSM states: IDLE, ARMED, HIGH, LOW.
//    IDLE : on a start strobe -> clear done and pulses_done. pulse_count==0 -> set done, stay IDLE.
//           Otherwise go ARMED if arm_on_trig, else HIGH on the next edge.
//    ARMED: trig rising edge (trig=1, trig_d=0) -> HIGH.
//    HIGH : timer_enable=1 for max(high_ticks,1) cycles. At the end, pulses_done+1.
//           Last pulse -> IDLE with done=1 (no trailing LOW). Otherwise -> LOW.
//    LOW  : timer_enable=0 for max(low_ticks,1) cycles -> HIGH.
//  timer_enable is registered and equals (state==HIGH).
//  busy = (state != IDLE), combinational from the state register.
//  First enable cycle is the second clk edge after the start strobe edge.
//  Tick counter: 32b down-counter loaded on entry to HIGH/LOW. A value of 0 is treated as 1.
//    No wrap: max 2^32-1 cycles per phase.
//  Config writes (+0..+9) while busy are ignored; values are sampled only at start.
//  Start while busy is ignored.
//  Abort (any state): -> IDLE next edge, timer_enable=0, done unchanged, pulses_done held.
//    Abort and start in the same write: abort wins.
//  Reset mid-sequence: everything returns to reset values on that edge.
//  trig edge outside ARMED is ignored; trig_d is sampled every cycle.
// STRUCTURE
//  Package timer_seq_pkg: state encoding constants, register offsets, ctrl/status bit positions.
//  Sub-module seq_phase_counter: 32b loadable down-counter with terminal-count flag,
//    used for both HIGH and LOW phases.
//  Top level holds the APB register file, FSM and pulses_done.
// TESTING
//  1. high=3, low=2, count=2, start -> enable 1 for 3 cycles, 0 for 2, 1 for 3, then idle;
//     done=1, pulses_done=2.
//  2. count=0, start -> no enable pulse; done=1 on the next edge; busy never asserted.
//  3. high=0, low=0, count=3 -> alternating 1/0 single cycles (1,0,1,0,1); pulses_done=3.
//  4. arm_on_trig=1, start, then hold trig low 10 cycles -> busy=1 and enable=0 throughout.
//     Pulse trig -> first HIGH begins on the next edge.
//  5. high=100, count=5, abort in the 2nd pulse -> enable=0 next edge; done=0; pulses_done=1.
//     Writing high=7 while busy -> reads back 100.
//  6. rst_n=0 during the LOW phase -> enable, busy, PRDATA, done and all registers read 0 after reset.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared encodings for the timer enable sequencer: FSM states, APB register offsets
// and the ctrl/status bit positions.
package timer_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

  localparam logic [11:0] OFS_HIGH   = 12'd0;
  localparam logic [11:0] OFS_LOW    = 12'd4;
  localparam logic [11:0] OFS_CNT    = 12'd8;
  localparam logic [11:0] OFS_CTRL   = 12'd10;
  localparam logic [11:0] OFS_STATUS = 12'd11;
  localparam logic [11:0] OFS_PDONE  = 12'd12;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_ARM   = 2;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable 32b down-counter timing one HIGH or LOW phase; tc marks the last cycle.
module seq_phase_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] load_val,
  output logic        tc
);

  logic [31:0] cnt;

  // A programmed length of 0 still yields a one-cycle phase.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= (load_val == 32'd0) ? 32'd1 : load_val;
    else if (en && cnt != 32'd0)
      cnt <= cnt - 32'd1;
  end

  assign tc = (cnt == 32'd1);

endmodule

// File: rtl/timer_enable_sequencer.sv
// APB-programmed generator of N enable pulses (HIGH ticks on, LOW ticks off) feeding
// the timer's logical_in[0].
module timer_enable_sequencer
  import timer_seq_pkg::*;
#(
  parameter int IO_LOGICAL = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  output logic        timer_enable,
  output logic        busy,
  input  logic [11:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PWDATA,
  output logic [7:0]  PRDATA
);

  if (IO_LOGICAL < 1) begin : g_bad_io_logical
    $error("IO_LOGICAL must be at least 1");
  end

  state_e      state;
  logic [31:0] high_ticks, low_ticks;
  logic [15:0] pulse_count, pulses_done, pulses_inc;
  logic        arm_on_trig, done, start_q, abort_q, trig_d;
  logic        wr, rd, trig_rise, last_pulse;
  logic        cnt_load, cnt_en, cnt_tc, go_high, go_low;
  logic [31:0] cnt_val;
  logic [7:0]  rdata;

  assign wr         = PSEL & PWRITE & PENABLE;
  assign rd         = PSEL & ~PWRITE;
  assign busy       = (state != ST_IDLE);
  assign trig_rise  = trig & ~trig_d;
  assign pulses_inc = pulses_done + 16'd1;
  assign last_pulse = (pulses_inc == pulse_count);

  // Register file. Ctrl strobes are held for one cycle and acted on by the FSM next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_ticks  <= '0;
      low_ticks   <= '0;
      pulse_count <= '0;
      arm_on_trig <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      PRDATA      <= '0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (wr) begin
        if (!busy) begin
          if (PADDR[11:2] == OFS_HIGH[11:2])
            high_ticks[{PADDR[1:0], 3'b000} +: 8] <= PWDATA;
          else if (PADDR[11:2] == OFS_LOW[11:2])
            low_ticks[{PADDR[1:0], 3'b000} +: 8] <= PWDATA;
          else if (PADDR == OFS_CNT)
            pulse_count[7:0] <= PWDATA;
          else if (PADDR == OFS_CNT + 12'd1)
            pulse_count[15:8] <= PWDATA;
        end
        if (PADDR == OFS_CTRL) begin
          start_q     <= PWDATA[CTRL_START];
          abort_q     <= PWDATA[CTRL_ABORT];
          arm_on_trig <= PWDATA[CTRL_ARM];
        end
      end
      if (rd)
        PRDATA <= rdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (PADDR[11:2] == OFS_HIGH[11:2])
      rdata = byte_of(high_ticks, PADDR[1:0]);
    else if (PADDR[11:2] == OFS_LOW[11:2])
      rdata = byte_of(low_ticks, PADDR[1:0]);
    else if (PADDR == OFS_CNT)
      rdata = pulse_count[7:0];
    else if (PADDR == OFS_CNT + 12'd1)
      rdata = pulse_count[15:8];
    else if (PADDR == OFS_STATUS) begin
      rdata[STAT_BUSY] = busy;
      rdata[STAT_DONE] = done;
    end else if (PADDR == OFS_PDONE)
      rdata = pulses_done[7:0];
    else if (PADDR == OFS_PDONE + 12'd1)
      rdata = pulses_done[15:8];
  end

  // Phase entry conditions, shared by the counter load and the FSM.
  always_comb begin
    go_high = 1'b0;
    go_low  = 1'b0;
    if (!abort_q) begin
      case (state)
        ST_IDLE:  go_high = start_q && !arm_on_trig && (pulse_count != 16'd0);
        ST_ARMED: go_high = trig_rise;
        ST_HIGH:  go_low  = cnt_tc && !last_pulse;
        ST_LOW:   go_high = cnt_tc;
        default:  go_high = 1'b0;
      endcase
    end
  end

  assign cnt_load = go_high | go_low;
  assign cnt_val  = go_low ? low_ticks : high_ticks;
  assign cnt_en   = (state == ST_HIGH) || (state == ST_LOW);

  seq_phase_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      timer_enable <= 1'b0;
      done         <= 1'b0;
      pulses_done  <= '0;
      trig_d       <= 1'b0;
    end else begin
      trig_d <= trig;
      if (abort_q) begin
        state        <= ST_IDLE;
        timer_enable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start_q) begin
            done        <= 1'b0;
            pulses_done <= '0;
            if (pulse_count == 16'd0)
              done <= 1'b1;
            else if (arm_on_trig)
              state <= ST_ARMED;
            else begin
              state        <= ST_HIGH;
              timer_enable <= 1'b1;
            end
          end
          ST_ARMED: if (trig_rise) begin
            state        <= ST_HIGH;
            timer_enable <= 1'b1;
          end
          ST_HIGH: if (cnt_tc) begin
            pulses_done  <= pulses_inc;
            timer_enable <= 1'b0;
            if (last_pulse) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else
              state <= ST_LOW;
          end
          ST_LOW: if (cnt_tc) begin
            state        <= ST_HIGH;
            timer_enable <= 1'b1;
          end
          default: begin
            state        <= ST_IDLE;
            timer_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
